// File: rtl/pop_timing_pkg.sv
// Shared definitions for the pulse timing chain.
//   pc_state_t : period_counter state encoding (IDLE, RUN, FINISH)
//   POP_WIDTH  : default count/period width, shared with the threshold
//                comparators so their `a` input matches `count`
//   POP_CWIDTH : default width of the period-repeat counter
package pop_timing_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } pc_state_t;

  localparam int POP_WIDTH  = 16;
  localparam int POP_CWIDTH = 16;

endpackage

// File: rtl/period_counter.sv
// Programmable period counter for the pulse timing chain.
// Produces a free-running count 0..period-1 that feeds the threshold
// comparators. Runs a programmed number of periods (cycles_in != 0) or
// continuously (cycles_in == 0). New period/cycle settings are staged in
// pending registers and only become active in IDLE or on a period boundary,
// so a period in progress is never shortened or stretched.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : one-cycle request to begin a run (ignored if period_act == 0)
//   abort     : one-cycle request to stop immediately (wins over start)
//   load      : one-cycle strobe capturing period_in/cycles_in as pending
//   period_in : new period length in clocks (0 is invalid)
//   cycles_in : periods per run, 0 = continuous
//   count     : current count, 0..period_act-1 (registered)
//   wrap      : high during the last count of each period
//   busy      : high while in RUN (registered)
//   done      : one-cycle pulse when a finite run completes (registered)
//   load_ack  : one-cycle pulse when pending values become active (registered)
module period_counter
  import pop_timing_pkg::*;
#(
  parameter int WIDTH  = POP_WIDTH,
  parameter int CWIDTH = POP_CWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              load,
  input  logic [WIDTH-1:0]  period_in,
  input  logic [CWIDTH-1:0] cycles_in,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              busy,
  output logic              done,
  output logic              load_ack
);

  localparam logic [WIDTH-1:0]  P_ONE = WIDTH'(1);
  localparam logic [CWIDTH-1:0] C_ONE = CWIDTH'(1);

  pc_state_t         state;
  logic [WIDTH-1:0]  period_act;
  logic [WIDTH-1:0]  period_pend;
  logic [CWIDTH-1:0] cycles_act;
  logic [CWIDTH-1:0] cycles_pend;
  logic [CWIDTH-1:0] remaining;
  logic              pend_valid;
  logic              apply;
  logic              last_period;

  // wrap is a pure decode of registered state and count, so it carries no
  // extra latency and cannot glitch toward the comparators.
  assign wrap = (state == RUN) && (count == period_act - P_ONE);

  // A load sampled on the same edge as a wrap only reaches pend_valid after
  // that edge, so it naturally waits for the following boundary.
  assign apply = pend_valid && ((state == IDLE) || wrap);

  assign last_period = wrap && (cycles_act != '0) && (remaining == C_ONE);

  // Pending values are pure data; pend_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (load) begin
      period_pend <= period_in;
      cycles_pend <= cycles_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ack   <= 1'b0;
      period_act <= '0;
      cycles_act <= '0;
      remaining  <= '0;
      pend_valid <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_ack <= 1'b0;

      // A fresh load overrides the clear so a capture coincident with an
      // apply stays pending for the next opportunity.
      if (load) begin
        pend_valid <= 1'b1;
      end else if (apply) begin
        pend_valid <= 1'b0;
      end

      if (apply) begin
        period_act <= period_pend;
        cycles_act <= cycles_pend;
        load_ack   <= 1'b1;
      end

      case (state)
        IDLE: begin
          count <= '0;
          // start uses the settings active before this edge
          if (start && !abort && (period_act != '0)) begin
            state     <= RUN;
            busy      <= 1'b1;
            remaining <= cycles_act;
          end
        end

        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else if (wrap) begin
            count <= '0;
            if (last_period) begin
              state     <= FINISH;
              busy      <= 1'b0;
              done      <= 1'b1;
              remaining <= '0;
            end else if (apply) begin
              // Newly applied cycle setting counts from the next period.
              remaining <= cycles_pend;
            end else if (cycles_act != '0) begin
              remaining <= remaining - C_ONE;
            end
          end else begin
            count <= count + P_ONE;
          end
        end

        FINISH: begin
          state <= IDLE;
          count <= '0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_counter.sv
module tb_period_counter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        load;
  logic [15:0] period_in;
  logic [15:0] cycles_in;
  logic [15:0] count;
  logic        wrap;
  logic        busy;
  logic        done;
  logic        load_ack;

  int checks;
  int failures;

  period_counter #(
    .WIDTH  (16),
    .CWIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .load      (load),
    .period_in (period_in),
    .cycles_in (cycles_in),
    .count     (count),
    .wrap      (wrap),
    .busy      (busy),
    .done      (done),
    .load_ack  (load_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] c, input logic w,
                         input logic b, input logic d, input logic la);
    chk({tag, ".count"},    {16'd0, count}, {16'd0, c});
    chk({tag, ".wrap"},     {31'd0, wrap},  {31'd0, w});
    chk({tag, ".busy"},     {31'd0, busy},  {31'd0, b});
    chk({tag, ".done"},     {31'd0, done},  {31'd0, d});
    chk({tag, ".load_ack"}, {31'd0, load_ack}, {31'd0, la});
  endtask

  initial begin
    int t1_cnt [10];
    int t2_cnt [7];
    int busy_cycles;
    int done_pulses;

    t1_cnt = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    t2_cnt = '{1, 2, 0, 1, 2, 0, 1};
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    load = 1'b0;
    period_in = '0;
    cycles_in = '0;

    // Reset state
    step();
    step();
    chk_out("reset", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("idle_after_reset", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Test 1: period=5 cycles=2
    load = 1'b1; period_in = 16'd5; cycles_in = 16'd2;
    step();
    load = 1'b0;
    chk_out("t1_captured", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("t1_applied", 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    busy_cycles = 0;
    done_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      start = 1'b0;
      chk_out($sformatf("t1_run%0d", i), t1_cnt[i][15:0], (t1_cnt[i] == 4), 1'b1, 1'b0, 1'b0);
      if (busy) busy_cycles++;
    end
    step();
    chk_out("t1_finish", 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    if (done) done_pulses++;
    if (busy) busy_cycles++;
    step();
    chk_out("t1_idle", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (done) done_pulses++;
    if (busy) busy_cycles++;
    chk("t1_busy_cycles", busy_cycles, 32'd10);
    chk("t1_done_pulses", done_pulses, 32'd1);

    // Test 2: continuous period=3, abort mid-period
    load = 1'b1; period_in = 16'd3; cycles_in = 16'd0;
    step();
    load = 1'b0;
    step();
    chk_out("t2_applied", 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("t2_run_start", 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk_out($sformatf("t2_run%0d", i), t2_cnt[i][15:0], (t2_cnt[i] == 2), 1'b1, 1'b0, 1'b0);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_out("t2_abort", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("t2_after_abort", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Test 3: period 8 running, load period 4 at count 2
    load = 1'b1; period_in = 16'd8; cycles_in = 16'd0;
    step();
    load = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("t3_c0", 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    chk_out("t3_c2", 16'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    load = 1'b1; period_in = 16'd4; cycles_in = 16'd0;
    step();
    load = 1'b0;
    chk_out("t3_c3", 16'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); step(); step(); step();
    chk_out("t3_c7_wrap", 16'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("t3_new_c0", 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(); step(); step();
    chk_out("t3_new_c3_wrap", 16'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    // Test 4: load coincident with wrap waits for the next boundary
    load = 1'b1; period_in = 16'd6; cycles_in = 16'd0;
    step();
    load = 1'b0;
    chk_out("t4_same_wrap", 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); step(); step();
    chk_out("t4_old_wrap", 16'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("t4_applied", 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(); step(); step(); step();
    chk_out("t4_c4", 16'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("t4_c5_wrap", 16'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("t4_c0", 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_out("t4_abort", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Test 5: period 0 start ignored; period 1 cycles 3
    load = 1'b1; period_in = 16'd0; cycles_in = 16'd0;
    step();
    load = 1'b0;
    step();
    chk_out("t5_p0_applied", 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("t5_p0_start", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b1; period_in = 16'd1; cycles_in = 16'd3;
    step();
    load = 1'b0;
    step();
    chk_out("t5_p1_applied", 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("t5_w1", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("t5_w2", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("t5_w3", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("t5_done", 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("t5_idle", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Test 6: start+abort in IDLE, then async reset mid-run
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk_out("t6_start_abort", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("t6_run", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    load = 1'b1; period_in = 16'd5; cycles_in = 16'd0;
    step();
    load = 1'b0;
    chk_out("t6_run2", 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("t6_async_reset", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    chk_out("t6_pend_lost", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("t6_period_cleared", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
